mag_ctrl_fsm: RTL and testbench
===============================

Name: mag_ctrl_fsm

Overview:
Parametrised successor to the microwave start/stop logic. Replaces the combinational S/R latch drive with a clocked controller that owns:
- the countdown timer
- pause/resume
- a programmable power level (duty cycle over seconds)
- a zero-latency door interlock on the magnetron enable.
It sits between the front-panel buttons and door switch and the magnetron driver and display.

Parameters:
TIME_W, 10, width of cook time in seconds (max 2^TIME_W-1).
PWR_STEPS, 10, number of seconds in one power-duty window.
PWR_W, 4, width of power_lvl; must satisfy 2^PWR_W > PWR_STEPS.

Ports:
clk  in  1  system clock
rst  in  1  reset, synchronous, active-high
startN  in  1  start button, active-low level
stopN  in  1  stop/pause button, active-low level
clearN  in  1  clear button, active-low level
door_closed  in  1  1 = door closed
tick_1s  in  1  one-cycle strobe, once per second
time_load  in  TIME_W  cook time sampled on start from IDLE
power_lvl  in  PWR_W  on-seconds per window, sampled on start from IDLE
mag_on  out  1  magnetron enable
time_left  out  TIME_W  remaining seconds
state  out  2  IDLE=0, COOK=1, PAUSE=2, DONE=3
done_pulse  out  1  one-cycle strobe on COOK->DONE

Behaviour:
- Reset: one clock, synchronous, active-high.
  - Outputs: state=IDLE, time_left=0, mag_on=0, done_pulse=0.
  - Internal: phase=0, power latch=0, button history regs=1 (no false edge after reset).
- Buttons: each has a history register. An event is a falling edge (prev=1, now=0), acted on in the cycle the low level is first sampled. Holding a button low produces exactly one event.
- Same-cycle priority: rst > door open > clear > stop > start > tick_1s.
- IDLE:
  - start event with door_closed=1 and time_load!=0: time_left<=time_load, latch power_lvl, phase<=0, go COOK.
  - time_load==0 or door open: start is ignored.
  - clear: time_left<=0.
- COOK:
  - door_closed=0: go PAUSE; time_left and phase held.
  - clear: go IDLE, time_left<=0.
  - stop: go PAUSE, counters held.
  - tick_1s:
    - time_left decrements.
    - phase advances 0..PWR_STEPS-1, then wraps to 0.
    - If time_left==1: time_left<=0, go DONE, done_pulse=1 next cycle for exactly one cycle.
  - Door-open and tick in the same cycle: no decrement.
- PAUSE:
  - start with door_closed=1: go COOK; time_left and phase resume unchanged.
  - stop or clear: go IDLE, time_left<=0.
  - tick_1s is ignored.
- DONE:
  - Any button event or door_closed=0: go IDLE.
  - time_left stays 0.
- mag_on = mag_q AND door_closed.
  - mag_q is registered: 1 iff next state is COOK and phase(next) < latched power.
  - Power >= PWR_STEPS means always on; power 0 means never on.
  - The combinational door gate guarantees mag_on falls in the same cycle the door opens (zero latency). This is the safety requirement.
- Widths: time_left never underflows (decrement only when non-zero in COOK). phase is clog2(PWR_STEPS) bits.
- Mid-operation rst: immediate return to reset values on the next edge; mag_on=0 from that edge.

Decomposition:
- Shared package mag_pkg:
  - state enum/encoding (IDLE, COOK, PAUSE, DONE)
  - default TIME_W/PWR_STEPS constants.
- One sub-module btn_edge_n, instantiated three times: registered active-low falling-edge detector, history reset to 1 under synchronous rst.

Test Plan:
- Basic cook:
  - Stimulus: rst, then time_load=3, power_lvl=10, start event, 3 ticks.
  - Response: state COOK; time_left 3->2->1->0; mag_on=1 throughout COOK; DONE with done_pulse high exactly 1 cycle; mag_on=0.
- Door interlock:
  - Stimulus: in COOK with time_left=5, drop door_closed.
  - Response: mag_on=0 in the same cycle; state PAUSE next edge; time_left=5 held.
  - Then close the door and start: COOK resumes at 5.
- Power duty:
  - Stimulus: PWR_STEPS=10, power_lvl=3, time_load=20, 20 ticks.
  - Response: mag_on high in seconds 0-2 and 10-12, low otherwise.
- Ignored and priority inputs:
  - start with door open or time_load=0 -> stays IDLE.
  - clear+start in the same cycle in COOK -> IDLE, time_left=0.
  - Door-open plus tick in the same cycle -> no decrement.
- Held button:
  - Stimulus: stopN held low 50 cycles in COOK.
  - Response: single PAUSE transition; no return to IDLE until stopN releases and presses again.
- Reset mid-cook:
  - Stimulus: rst pulse with time_left=7.
  - Response: state IDLE, time_left=0, mag_on=0 after the edge.
  - Button held low through reset then held: no event.

Source files
------------

// File: rtl/mag_pkg.sv
// ---------------------------------------------------------------------------
// mag_pkg
// Shared definitions for the microwave magnetron controller.
//   - Default parameter values for cook-time width, power window length and
//     power-level width.
//   - State encoding, kept as plain 2-bit constants so the value on the
//     state output matches the legacy display decoder: IDLE=0, COOK=1,
//     PAUSE=2, DONE=3.
//   - Bundle type for the three front-panel button events.
// ---------------------------------------------------------------------------
package mag_pkg;

    // Default sizing.
    localparam int TIME_W_DEF    = 10;  // cook time in seconds, max 1023
    localparam int PWR_STEPS_DEF = 10;  // seconds per power-duty window
    localparam int PWR_W_DEF     = 4;   // 2**PWR_W must exceed PWR_STEPS

    // Controller states.
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_COOK  = 2'd1;
    localparam logic [1:0] ST_PAUSE = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    // One-cycle button events, already edge-detected.
    typedef struct packed {
        logic start;
        logic stop;
        logic clear;
    } btn_ev_t;

endpackage

// File: rtl/btn_edge_n.sv
// ---------------------------------------------------------------------------
// btn_edge_n
// Falling-edge detector for an active-low, level-type push button.
// The event is combinational on the current button level against the
// registered history, so the controller reacts in the same cycle the low
// level is first sampled. Holding the button low yields exactly one event.
//
// Ports:
//   clk    in   system clock
//   rst    in   synchronous active-high reset
//   btn_n  in   raw button level, 0 = pressed
//   fall   out  one-cycle event on a 1 -> 0 transition
//
// History resets to 1 so a released button cannot raise an event after
// reset. A separate arm flag samples the button during reset: a button
// that is already held down while reset is asserted stays disarmed until
// it has been seen released once, so it cannot fire a stale press.
// ---------------------------------------------------------------------------
module btn_edge_n (
    input  logic clk,
    input  logic rst,
    input  logic btn_n,
    output logic fall
);

    logic hist;
    logic armed;

    always_ff @(posedge clk) begin
        if (rst) begin
            hist  <= 1'b1;
            armed <= btn_n;
        end else begin
            hist  <= btn_n;
            armed <= armed | btn_n;
        end
    end

    assign fall = hist & ~btn_n & armed;

endmodule

// File: rtl/mag_ctrl_fsm.sv
// ---------------------------------------------------------------------------
// mag_ctrl_fsm
// Clocked microwave controller: countdown timer, pause/resume, power-level
// duty cycling over a window of PWR_STEPS seconds, and a zero-latency door
// interlock on the magnetron enable.
//
// Ports:
//   clk          in   system clock
//   rst          in   synchronous active-high reset
//   startN       in   start button, active-low level
//   stopN        in   stop/pause button, active-low level
//   clearN       in   clear button, active-low level
//   door_closed  in   1 = door closed
//   tick_1s      in   one-cycle strobe, once per second
//   time_load    in   cook time, sampled on start from IDLE
//   power_lvl    in   on-seconds per window, sampled on start from IDLE
//   mag_on       out  magnetron enable (gated combinationally by the door)
//   time_left    out  remaining seconds
//   state        out  IDLE=0, COOK=1, PAUSE=2, DONE=3
//   done_pulse   out  one-cycle strobe on COOK -> DONE
//
// Same-cycle priority: rst > door open > clear > stop > start > tick_1s.
// A start event while cooking has no meaning and does not block the tick.
// ---------------------------------------------------------------------------
module mag_ctrl_fsm
    import mag_pkg::*;
#(
    parameter int TIME_W    = TIME_W_DEF,
    parameter int PWR_STEPS = PWR_STEPS_DEF,
    parameter int PWR_W     = PWR_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              startN,
    input  logic              stopN,
    input  logic              clearN,
    input  logic              door_closed,
    input  logic              tick_1s,
    input  logic [TIME_W-1:0] time_load,
    input  logic [PWR_W-1:0]  power_lvl,
    output logic              mag_on,
    output logic [TIME_W-1:0] time_left,
    output logic [1:0]        state,
    output logic              done_pulse
);

    localparam int PH_W  = (PWR_STEPS > 1) ? $clog2(PWR_STEPS) : 1;
    localparam int CMP_W = (PH_W > PWR_W) ? PH_W : PWR_W;

    localparam logic [PH_W-1:0]   PH_LAST  = PH_W'(PWR_STEPS - 1);
    localparam logic [TIME_W-1:0] TIME_ONE = TIME_W'(1);

    // -----------------------------------------------------------------------
    // Button edge detection
    // -----------------------------------------------------------------------
    logic    start_ev;
    logic    stop_ev;
    logic    clear_ev;
    btn_ev_t ev;
    logic    any_ev;

    btn_edge_n u_start (
        .clk   (clk),
        .rst   (rst),
        .btn_n (startN),
        .fall  (start_ev)
    );

    btn_edge_n u_stop (
        .clk   (clk),
        .rst   (rst),
        .btn_n (stopN),
        .fall  (stop_ev)
    );

    btn_edge_n u_clear (
        .clk   (clk),
        .rst   (rst),
        .btn_n (clearN),
        .fall  (clear_ev)
    );

    assign ev     = '{start: start_ev, stop: stop_ev, clear: clear_ev};
    assign any_ev = ev.start | ev.stop | ev.clear;

    // -----------------------------------------------------------------------
    // State registers
    // -----------------------------------------------------------------------
    logic [PH_W-1:0]   phase;
    logic [PWR_W-1:0]  power_q;
    logic              mag_q;

    logic [1:0]        state_n;
    logic [TIME_W-1:0] time_n;
    logic [PH_W-1:0]   phase_n;
    logic [PWR_W-1:0]  power_n;
    logic              mag_n;
    logic              done_n;

    // Phase position within the power window after one more second.
    logic [PH_W-1:0]   phase_adv;
    assign phase_adv = (phase == PH_LAST) ? '0 : phase + PH_W'(1);

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_n = state;
        time_n  = time_left;
        phase_n = phase;
        power_n = power_q;
        done_n  = 1'b0;

        case (state)
            ST_IDLE: begin
                if (ev.clear) begin
                    time_n = '0;
                end else if (ev.stop) begin
                    // Stop outranks start; nothing to stop while idle.
                    state_n = ST_IDLE;
                end else if (ev.start && door_closed && (time_load != '0)) begin
                    time_n  = time_load;
                    power_n = power_lvl;
                    phase_n = '0;
                    state_n = ST_COOK;
                end
            end

            ST_COOK: begin
                if (!door_closed) begin
                    // Counters freeze; the tick in this cycle is dropped.
                    state_n = ST_PAUSE;
                end else if (ev.clear) begin
                    time_n  = '0;
                    state_n = ST_IDLE;
                end else if (ev.stop) begin
                    state_n = ST_PAUSE;
                end else if (tick_1s && (time_left != '0)) begin
                    phase_n = phase_adv;
                    if (time_left == TIME_ONE) begin
                        time_n  = '0;
                        state_n = ST_DONE;
                        done_n  = 1'b1;
                    end else begin
                        time_n = time_left - TIME_ONE;
                    end
                end
            end

            ST_PAUSE: begin
                if (ev.clear || ev.stop) begin
                    time_n  = '0;
                    state_n = ST_IDLE;
                end else if (ev.start && door_closed) begin
                    state_n = ST_COOK;
                end
            end

            ST_DONE: begin
                time_n = '0;
                if (any_ev || !door_closed) begin
                    state_n = ST_IDLE;
                end
            end

            default: begin
                time_n  = '0;
                state_n = ST_IDLE;
            end
        endcase

        // Power >= PWR_STEPS is always on because phase never reaches
        // PWR_STEPS; power 0 is never on.
        mag_n = (state_n == ST_COOK) && (CMP_W'(phase_n) < CMP_W'(power_n));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            time_left  <= '0;
            phase      <= '0;
            power_q    <= '0;
            mag_q      <= 1'b0;
            done_pulse <= 1'b0;
        end else begin
            state      <= state_n;
            time_left  <= time_n;
            phase      <= phase_n;
            power_q    <= power_n;
            mag_q      <= mag_n;
            done_pulse <= done_n;
        end
    end

    // Door gate is combinational so the enable drops in the same cycle the
    // door opens, without waiting for the state register.
    assign mag_on = mag_q & door_closed;

endmodule

// File: tb/tb_mag_ctrl_fsm.sv
// ---------------------------------------------------------------------------
// tb_mag_ctrl_fsm
// Self-checking bench for mag_ctrl_fsm with default parameters
// (TIME_W=10, PWR_STEPS=10, PWR_W=4).
// Each cycle the expected {state, time_left, mag_on, done_pulse} is pushed
// to exp_q when inputs are driven and popped and compared 1 time unit
// after the next rising edge.
// ---------------------------------------------------------------------------
module tb_mag_ctrl_fsm;

    localparam int TIME_W    = 10;
    localparam int PWR_STEPS = 10;
    localparam int PWR_W     = 4;
    localparam int OBS_W     = 2 + TIME_W + 2;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_COOK  = 2'd1;
    localparam logic [1:0] S_PAUSE = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic              clk = 1'b0;
    logic              rst;
    logic              startN;
    logic              stopN;
    logic              clearN;
    logic              door_closed;
    logic              tick_1s;
    logic [TIME_W-1:0] time_load;
    logic [PWR_W-1:0]  power_lvl;
    logic              mag_on;
    logic [TIME_W-1:0] time_left;
    logic [1:0]        state;
    logic              done_pulse;

    int checks = 0;
    int errors = 0;

    logic [OBS_W-1:0] exp_q[$];

    typedef struct packed {
        logic              start_n;
        logic              stop_n;
        logic              clear_n;
        logic              door;
        logic              tick;
        logic [TIME_W-1:0] tload;
        logic [PWR_W-1:0]  plvl;
        logic [1:0]        e_state;
        logic [TIME_W-1:0] e_time;
        logic              e_mag;
        logic              e_done;
    } vec_t;

    vec_t vecs[$];

    // ---------------------------------------------------------------------
    // Clock and DUT
    // ---------------------------------------------------------------------
    always #5 clk = ~clk;

    mag_ctrl_fsm #(
        .TIME_W    (TIME_W),
        .PWR_STEPS (PWR_STEPS),
        .PWR_W     (PWR_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .startN      (startN),
        .stopN       (stopN),
        .clearN      (clearN),
        .door_closed (door_closed),
        .tick_1s     (tick_1s),
        .time_load   (time_load),
        .power_lvl   (power_lvl),
        .mag_on      (mag_on),
        .time_left   (time_left),
        .state       (state),
        .done_pulse  (done_pulse)
    );

    // ---------------------------------------------------------------------
    // Driver tasks and scoreboard
    // ---------------------------------------------------------------------
    function automatic vec_t mk(input logic s, input logic sp, input logic c,
                                input logic d, input logic t,
                                input int tl, input int pl,
                                input logic [1:0] es, input int et,
                                input logic em, input logic ed);
        vec_t v;
        v.start_n = s;
        v.stop_n  = sp;
        v.clear_n = c;
        v.door    = d;
        v.tick    = t;
        v.tload   = TIME_W'(tl);
        v.plvl    = PWR_W'(pl);
        v.e_state = es;
        v.e_time  = TIME_W'(et);
        v.e_mag   = em;
        v.e_done  = ed;
        return v;
    endfunction

    task automatic set_in(input logic s, input logic sp, input logic c,
                          input logic d, input logic t);
        startN      = s;
        stopN       = sp;
        clearN      = c;
        door_closed = d;
        tick_1s     = t;
    endtask

    task automatic compare_out(input string name);
        logic [OBS_W-1:0] e;
        logic [OBS_W-1:0] a;
        e = exp_q.pop_front();
        a = {state, time_left, mag_on, done_pulse};
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got state=%0d time_left=%0d mag_on=%0b done_pulse=%0b, want state=%0d time_left=%0d mag_on=%0b done_pulse=%0b",
                     name, a[OBS_W-1 -: 2], a[TIME_W+1:2], a[1], a[0],
                     e[OBS_W-1 -: 2], e[TIME_W+1:2], e[1], e[0]);
        end
    endtask

    // Push the expectation for the next edge, clock once, then compare.
    task automatic expect_cycle(input string name, input logic [1:0] s,
                                input int t, input logic m, input logic d);
        exp_q.push_back({s, TIME_W'(t), m, d});
        @(posedge clk);
        #1;
        compare_out(name);
    endtask

    task automatic check_val(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    // ---------------------------------------------------------------------
    // Stimulus
    // ---------------------------------------------------------------------
    initial begin
        // Basic cook, ignored starts, clear+start priority, door+tick.
        vecs.push_back(mk(1,1,1,1,0, 3,10, S_IDLE, 0,0,0));
        vecs.push_back(mk(0,1,1,1,0, 3,10, S_COOK, 3,1,0));
        vecs.push_back(mk(1,1,1,1,0, 3,10, S_COOK, 3,1,0));
        vecs.push_back(mk(1,1,1,1,1, 0, 0, S_COOK, 2,1,0));
        vecs.push_back(mk(1,1,1,1,0, 0, 0, S_COOK, 2,1,0));
        vecs.push_back(mk(1,1,1,1,1, 0, 0, S_COOK, 1,1,0));
        vecs.push_back(mk(1,1,1,1,1, 0, 0, S_DONE, 0,0,1));
        vecs.push_back(mk(1,1,1,1,0, 0, 0, S_DONE, 0,0,0));
        vecs.push_back(mk(1,0,1,1,0, 0, 0, S_IDLE, 0,0,0));
        vecs.push_back(mk(1,1,1,1,0, 5,10, S_IDLE, 0,0,0));
        vecs.push_back(mk(0,1,1,0,0, 5,10, S_IDLE, 0,0,0));
        vecs.push_back(mk(1,1,1,1,0, 0,10, S_IDLE, 0,0,0));
        vecs.push_back(mk(0,1,1,1,0, 0,10, S_IDLE, 0,0,0));
        vecs.push_back(mk(1,1,1,1,0, 5,10, S_IDLE, 0,0,0));
        vecs.push_back(mk(0,1,1,1,0, 5,10, S_COOK, 5,1,0));
        vecs.push_back(mk(1,1,1,1,1, 5,10, S_COOK, 4,1,0));
        vecs.push_back(mk(0,1,0,1,0, 5,10, S_IDLE, 0,0,0));
        vecs.push_back(mk(1,1,1,1,0, 6,10, S_IDLE, 0,0,0));
        vecs.push_back(mk(0,1,1,1,0, 6,10, S_COOK, 6,1,0));
        vecs.push_back(mk(1,1,1,0,1, 6,10, S_PAUSE,6,0,0));
        vecs.push_back(mk(1,1,1,1,1, 6,10, S_PAUSE,6,0,0));
        vecs.push_back(mk(0,1,1,1,0, 6,10, S_COOK, 6,1,0));
        vecs.push_back(mk(1,1,1,1,1, 6,10, S_COOK, 5,1,0));
        vecs.push_back(mk(1,0,1,1,0, 6,10, S_PAUSE,5,0,0));
        vecs.push_back(mk(1,1,1,1,0, 6,10, S_PAUSE,5,0,0));
        vecs.push_back(mk(1,0,1,1,0, 6,10, S_IDLE, 0,0,0));
        vecs.push_back(mk(1,1,1,1,0, 6,10, S_IDLE, 0,0,0));

        // Reset
        set_in(1, 1, 1, 1, 0);
        time_load = '0;
        power_lvl = '0;
        rst       = 1'b1;
        expect_cycle("reset", S_IDLE, 0, 1'b0, 1'b0);
        rst = 1'b0;

        // Table-driven vectors
        for (int i = 0; i < vecs.size(); i++) begin
            set_in(vecs[i].start_n, vecs[i].stop_n, vecs[i].clear_n,
                   vecs[i].door, vecs[i].tick);
            time_load = vecs[i].tload;
            power_lvl = vecs[i].plvl;
            expect_cycle($sformatf("vec%0d", i), vecs[i].e_state,
                         int'(vecs[i].e_time), vecs[i].e_mag, vecs[i].e_done);
        end

        // Door interlock: mag_on must drop before the next edge.
        time_load = TIME_W'(5);
        power_lvl = PWR_W'(10);
        set_in(0, 1, 1, 1, 0);
        expect_cycle("intlk_start", S_COOK, 5, 1'b1, 1'b0);
        set_in(1, 1, 1, 1, 0);
        expect_cycle("intlk_cook", S_COOK, 5, 1'b1, 1'b0);
        door_closed = 1'b0;
        #1;
        check_val("intlk_zero_latency", int'(mag_on), 0);
        check_val("intlk_state_same_cycle", int'(state), int'(S_COOK));
        expect_cycle("intlk_pause", S_PAUSE, 5, 1'b0, 1'b0);
        door_closed = 1'b1;
        expect_cycle("intlk_closed", S_PAUSE, 5, 1'b0, 1'b0);
        set_in(0, 1, 1, 1, 0);
        expect_cycle("intlk_resume", S_COOK, 5, 1'b1, 1'b0);
        set_in(1, 0, 1, 1, 0);
        expect_cycle("intlk_stop1", S_PAUSE, 5, 1'b0, 1'b0);
        set_in(1, 1, 1, 1, 0);
        expect_cycle("intlk_rel", S_PAUSE, 5, 1'b0, 1'b0);
        set_in(1, 0, 1, 1, 0);
        expect_cycle("intlk_stop2", S_IDLE, 0, 1'b0, 1'b0);

        // Power duty: power 3 in a 10-second window over 20 seconds.
        time_load = TIME_W'(20);
        power_lvl = PWR_W'(3);
        set_in(0, 1, 1, 1, 0);
        expect_cycle("duty_start", S_COOK, 20, 1'b1, 1'b0);
        for (int k = 1; k <= 20; k++) begin
            set_in(1, 1, 1, 1, 1);
            if (k < 20)
                expect_cycle($sformatf("duty_s%0d", k), S_COOK, 20 - k,
                             ((k % PWR_STEPS) < 3), 1'b0);
            else
                expect_cycle("duty_done", S_DONE, 0, 1'b0, 1'b1);
        end
        set_in(1, 1, 1, 0, 0);
        expect_cycle("done_door_exit", S_IDLE, 0, 1'b0, 1'b0);
        door_closed = 1'b1;
        expect_cycle("done_idle", S_IDLE, 0, 1'b0, 1'b0);

        // Held stop button: one PAUSE transition only.
        time_load = TIME_W'(10);
        power_lvl = PWR_W'(10);
        set_in(0, 1, 1, 1, 0);
        expect_cycle("hold_start", S_COOK, 10, 1'b1, 1'b0);
        set_in(1, 1, 1, 1, 0);
        expect_cycle("hold_cook", S_COOK, 10, 1'b1, 1'b0);
        for (int c = 0; c < 50; c++) begin
            set_in(1, 0, 1, 1, 0);
            expect_cycle($sformatf("hold_c%0d", c), S_PAUSE, 10, 1'b0, 1'b0);
        end
        set_in(1, 1, 1, 1, 0);
        expect_cycle("hold_release", S_PAUSE, 10, 1'b0, 1'b0);
        set_in(1, 0, 1, 1, 0);
        expect_cycle("hold_repress", S_IDLE, 0, 1'b0, 1'b0);
        set_in(1, 1, 1, 1, 0);
        expect_cycle("hold_idle", S_IDLE, 0, 1'b0, 1'b0);

        // Reset mid-cook.
        time_load = TIME_W'(7);
        set_in(0, 1, 1, 1, 0);
        expect_cycle("rst_start", S_COOK, 7, 1'b1, 1'b0);
        set_in(1, 1, 1, 1, 0);
        expect_cycle("rst_cook", S_COOK, 7, 1'b1, 1'b0);
        rst = 1'b1;
        expect_cycle("rst_mid_cook", S_IDLE, 0, 1'b0, 1'b0);
        rst = 1'b0;

        // Start held low through reset must not start a cook.
        time_load = TIME_W'(5);
        set_in(0, 1, 1, 1, 0);
        rst = 1'b1;
        expect_cycle("rst_held", S_IDLE, 0, 1'b0, 1'b0);
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            expect_cycle($sformatf("rst_held_c%0d", c), S_IDLE, 0, 1'b0, 1'b0);
        end
        set_in(1, 1, 1, 1, 0);
        expect_cycle("rst_held_rel", S_IDLE, 0, 1'b0, 1'b0);
        set_in(0, 1, 1, 1, 0);
        expect_cycle("rst_held_press", S_COOK, 5, 1'b1, 1'b0);
        set_in(1, 1, 0, 1, 0);
        expect_cycle("rst_held_clear", S_IDLE, 0, 1'b0, 1'b0);

        check_val("scoreboard_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
